alu_op_sequencer: RTL

- Generalises the ALU opcode decoder into a registered, handshaked op issue stage.
- Decodes an OPW-bit ALU opcode into a NUM_OPS-wide one-hot enable vector.
- Holds the enables for the full duration of single-cycle ops (add/sub/and/or/sll/sra) and multi-cycle ops (mul/div).
- Sits between the execute-stage control and the ALU/multdiv datapath; produces the start pulse, result-valid handshake and illegal-opcode flag.

---
 rtl/alu_op_pkg.sv | 42 ++++
 rtl/alu_op_onehot_dec.sv | 29 ++
 rtl/alu_op_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_op_pkg.sv
// alu_op_pkg: shared constants for the ALU op issue stage.
//   - opcode values for the eight defined ALU operations
//   - enable-vector bit indices (equal to the opcode value)
//   - sequencer state encoding
//   - default widths and multi-cycle latencies
package alu_op_pkg;

  // Default geometry and latencies
  localparam int unsigned DEF_OPW        = 5;
  localparam int unsigned DEF_NUM_OPS    = 8;
  localparam int unsigned DEF_MUL_CYCLES = 17;
  localparam int unsigned DEF_DIV_CYCLES = 33;
  localparam int unsigned DEF_CNT_W      = 16;

  // Opcode map
  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_SLL = 4;
  localparam int unsigned OP_SRA = 5;
  localparam int unsigned OP_MUL = 6;
  localparam int unsigned OP_DIV = 7;

  // Enable bit positions match the opcode values
  localparam int unsigned EN_ADD = OP_ADD;
  localparam int unsigned EN_SUB = OP_SUB;
  localparam int unsigned EN_AND = OP_AND;
  localparam int unsigned EN_OR  = OP_OR;
  localparam int unsigned EN_SLL = OP_SLL;
  localparam int unsigned EN_SRA = OP_SRA;
  localparam int unsigned EN_MUL = OP_MUL;
  localparam int unsigned EN_DIV = OP_DIV;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_e;

endpackage : alu_op_pkg

// File: rtl/alu_op_onehot_dec.sv
// alu_op_onehot_dec: combinational opcode decode.
// Ports:
//   opcode     in  OPW      ALU opcode
//   onehot     out NUM_OPS  one-hot enable (all zero for undefined codes)
//   illegal    out 1        opcode is not one of the defined operations
//   multicycle out 1        opcode is mul or div
module alu_op_onehot_dec
  import alu_op_pkg::*;
#(
  parameter int unsigned OPW     = DEF_OPW,
  parameter int unsigned NUM_OPS = DEF_NUM_OPS
) (
  input  logic [OPW-1:0]     opcode,
  output logic [NUM_OPS-1:0] onehot,
  output logic               illegal,
  output logic               multicycle
);

  // Bit i set exactly when opcode equals i; undefined codes leave the vector zero
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      if (opcode == OPW'(i)) onehot[i] = 1'b1;
    end
    illegal    = ~|onehot;
    multicycle = onehot[EN_MUL] | onehot[EN_DIV];
  end

endmodule : alu_op_onehot_dec

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registered, handshaked ALU op issue stage.
// Accepts an opcode, drives a held one-hot enable for the op's duration,
// pulses out_start on the first cycle, and raises out_valid after the op's
// latency (1 for single-cycle/illegal ops, MUL_CYCLES/DIV_CYCLES otherwise).
// Ports:
//   clock        in  1        system clock, rising edge
//   reset        in  1        synchronous active-high reset
//   in_valid     in  1        opcode offered
//   in_opcode    in  OPW      ALU opcode
//   in_ready     out 1        sequencer can accept this cycle (combinational)
//   out_enables  out NUM_OPS  registered one-hot op enable
//   out_start    out 1        one-cycle pulse on first cycle of an accepted op
//   out_valid    out 1        result of current op valid
//   out_ready    in  1        consumer takes result
//   out_illegal  out 1        current op opcode undefined
//   busy         out 1        op in flight
//   op_count     out CNT_W    accepted ops, wraps
module alu_op_sequencer
  import alu_op_pkg::*;
#(
  parameter int unsigned OPW        = DEF_OPW,
  parameter int unsigned NUM_OPS    = DEF_NUM_OPS,
  parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [OPW-1:0]     in_opcode,
  output logic               in_ready,
  output logic [NUM_OPS-1:0] out_enables,
  output logic               out_start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_illegal,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  // Counter only ever holds LAT-2, so log2 of the longest latency is enough
  localparam int unsigned MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CYC_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  seq_state_e         state;
  logic [CYC_W-1:0]   cyc;
  logic [NUM_OPS-1:0] dec_onehot;
  logic               dec_illegal;
  logic               dec_multi;
  logic               accept;

  alu_op_onehot_dec #(
    .OPW     (OPW),
    .NUM_OPS (NUM_OPS)
  ) u_dec (
    .opcode     (in_opcode),
    .onehot     (dec_onehot),
    .illegal    (dec_illegal),
    .multicycle (dec_multi)
  );

  // Ready when idle, or when the held result is being taken this cycle
  assign in_ready = !reset && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  // Sequencer state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cyc         <= '0;
      out_enables <= '0;
      out_start   <= 1'b0;
      out_valid   <= 1'b0;
      out_illegal <= 1'b0;
      busy        <= 1'b0;
      op_count    <= '0;
    end else begin
      out_start <= 1'b0;
      if (accept) begin
        out_enables <= dec_onehot;
        out_illegal <= dec_illegal;
        out_start   <= 1'b1;
        busy        <= 1'b1;
        op_count    <= op_count + CNT_W'(1);
        if (dec_multi) begin
          // EXEC spans LAT-1 cycles; the counter counts down to zero across them
          state     <= ST_EXEC;
          out_valid <= 1'b0;
          cyc       <= dec_onehot[EN_DIV] ? CYC_W'(DIV_CYCLES - 2) : CYC_W'(MUL_CYCLES - 2);
        end else begin
          state     <= ST_HOLD;
          out_valid <= 1'b1;
          cyc       <= '0;
        end
      end else begin
        case (state)
          ST_EXEC: begin
            if (cyc == '0) begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
            end else begin
              cyc <= cyc - CYC_W'(1);
            end
          end
          ST_HOLD: begin
            if (out_ready) begin
              state       <= ST_IDLE;
              out_valid   <= 1'b0;
              out_enables <= '0;
              out_illegal <= 1'b0;
              busy        <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule : alu_op_sequencer
